hazard_ctrl: RTL and testbench

Pipeline hazard and run-control unit for the 5-stage MIPS core. Combinationally resolves forwarding, load-use stalls and branch-operand stalls for the IF/ID/EX stages. A registered run FSM detects end of program (consecutive invalid fetches), drains in-flight instructions, pulses a register-file dump and halts the pipe. Saturating counters record stall statistics.

---
 rtl/hazard_ctrl_pkg.sv | 21 ++
 rtl/hazard_ctrl_detect.sv | 54 +++++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard / run-control unit: run-FSM encoding,
// EX forward-select codes and the register-match rule.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DUMP  = 2'd2,
        ST_HALT  = 2'd3
    } run_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // $0 is hard-wired zero, so a source of 0 never depends on anything.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Purely combinational forwarding and stall equations for the ID/EX stages.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic       branch_i,
    input  logic [4:0] rs_d_i,
    input  logic [4:0] rt_d_i,
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rt_e_i,
    input  logic [4:0] write_reg_e_i,
    input  logic [4:0] write_reg_m_i,
    input  logic [4:0] write_reg_w_i,
    input  logic       reg_write_e_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    input  logic       mem_to_reg_e_i,
    input  logic       mem_to_reg_m_i,
    output logic       forward_ad_o,
    output logic       forward_bd_o,
    output logic [1:0] forward_ae_o,
    output logic [1:0] forward_be_o,
    output logic       lw_stall_o,
    output logic       br_stall_o
);

    function automatic logic [1:0] ex_select(input logic [4:0] src);
        if (reg_write_m_i && reg_match(src, write_reg_m_i))
            return FWD_MEM;
        else if (reg_write_w_i && reg_match(src, write_reg_w_i))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    logic ex_dep;
    logic mem_load_dep;

    assign forward_ae_o = ex_select(rs_e_i);
    assign forward_be_o = ex_select(rt_e_i);

    assign forward_ad_o = reg_write_m_i && reg_match(rs_d_i, write_reg_m_i);
    assign forward_bd_o = reg_write_m_i && reg_match(rt_d_i, write_reg_m_i);

    assign lw_stall_o = mem_to_reg_e_i &&
                        (reg_match(rs_d_i, rt_e_i) || reg_match(rt_d_i, rt_e_i));

    // A branch compares in ID, so it must wait for any EX result and for a load still in MEM.
    assign ex_dep       = reg_write_e_i &&
                          (reg_match(rs_d_i, write_reg_e_i) || reg_match(rt_d_i, write_reg_e_i));
    assign mem_load_dep = mem_to_reg_m_i &&
                          (reg_match(rs_d_i, write_reg_m_i) || reg_match(rt_d_i, write_reg_m_i));
    assign br_stall_o   = branch_i && (ex_dep || mem_load_dep);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard resolution plus run control: detects end of program, drains the pipe,
// pulses a register dump, halts, and keeps saturating stall statistics.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int IDLE_LIMIT   = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid_d,
    input  logic             branch_d,
    input  logic             pcsrc_d,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic [4:0]       rs_e,
    input  logic [4:0]       rt_e,
    input  logic [4:0]       write_reg_e,
    input  logic [4:0]       write_reg_m,
    input  logic [4:0]       write_reg_w,
    input  logic             reg_write_e,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             mem_to_reg_e,
    input  logic             mem_to_reg_m,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             forward_ad,
    output logic             forward_bd,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic             dump_regs,
    output logic             halt,
    output logic [CNT_W-1:0] lw_stall_cnt,
    output logic [CNT_W-1:0] br_stall_cnt
);

    localparam int IDLE_W  = (IDLE_LIMIT   > 1) ? $clog2(IDLE_LIMIT)   : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_LIMIT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    run_state_e         state_q, state_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]   lw_cnt_q, lw_cnt_d;
    logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;

    logic lw_stall;
    logic br_stall;
    logic running;
    logic hold;

    hazard_detect u_detect (
        .branch_i       (branch_d),
        .rs_d_i         (rs_d),
        .rt_d_i         (rt_d),
        .rs_e_i         (rs_e),
        .rt_e_i         (rt_e),
        .write_reg_e_i  (write_reg_e),
        .write_reg_m_i  (write_reg_m),
        .write_reg_w_i  (write_reg_w),
        .reg_write_e_i  (reg_write_e),
        .reg_write_m_i  (reg_write_m),
        .reg_write_w_i  (reg_write_w),
        .mem_to_reg_e_i (mem_to_reg_e),
        .mem_to_reg_m_i (mem_to_reg_m),
        .forward_ad_o   (forward_ad),
        .forward_bd_o   (forward_bd),
        .forward_ae_o   (forward_ae),
        .forward_be_o   (forward_be),
        .lw_stall_o     (lw_stall),
        .br_stall_o     (br_stall)
    );

    assign running = (state_q == ST_RUN);

    // Outside RUN the front end is frozen and EX only ever receives bubbles.
    assign hold      = running ? (lw_stall || br_stall) : 1'b1;
    assign stall_f   = hold;
    assign stall_d   = hold;
    assign flush_e   = hold;
    assign flush_d   = pcsrc_d && !hold;
    assign dump_regs = (state_q == ST_DUMP);
    assign halt      = (state_q == ST_HALT);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (instr_valid_d) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d     = ST_DRAIN;
                    idle_cnt_d  = '0;
                    drain_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST)
                    state_d = ST_DUMP;
                else
                    drain_cnt_d = drain_cnt_q + 1'b1;
            end
            ST_DUMP: state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // A cycle with both hazards is one stall, attributed to the load.
    always_comb begin
        lw_cnt_d = lw_cnt_q;
        br_cnt_d = br_cnt_q;
        if (running && lw_stall && (lw_cnt_q != '1))
            lw_cnt_d = lw_cnt_q + 1'b1;
        if (running && br_stall && !lw_stall && (br_cnt_q != '1))
            br_cnt_d = br_cnt_q + 1'b1;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            idle_cnt_q  <= '0;
            drain_cnt_q <= '0;
            lw_cnt_q    <= '0;
            br_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            lw_cnt_q    <= lw_cnt_d;
            br_cnt_q    <= br_cnt_d;
        end
    end

    assign lw_stall_cnt = lw_cnt_q;
    assign br_stall_cnt = br_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes model expectations, a
// negedge monitor pops and compares every DUT output.
module tb_hazard_ctrl;

    localparam int IDLE_LIMIT   = 5;
    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 16;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             instr_valid_d, branch_d, pcsrc_d;
    logic [4:0]       rs_d, rt_d, rs_e, rt_e;
    logic [4:0]       write_reg_e, write_reg_m, write_reg_w;
    logic             reg_write_e, reg_write_m, reg_write_w;
    logic             mem_to_reg_e, mem_to_reg_m;
    logic             stall_f, stall_d, flush_d, flush_e;
    logic             forward_ad, forward_bd;
    logic [1:0]       forward_ae, forward_be;
    logic             dump_regs, halt;
    logic [CNT_W-1:0] lw_stall_cnt, br_stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .IDLE_LIMIT   (IDLE_LIMIT),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid_d (instr_valid_d),
        .branch_d      (branch_d),
        .pcsrc_d       (pcsrc_d),
        .rs_d          (rs_d),
        .rt_d          (rt_d),
        .rs_e          (rs_e),
        .rt_e          (rt_e),
        .write_reg_e   (write_reg_e),
        .write_reg_m   (write_reg_m),
        .write_reg_w   (write_reg_w),
        .reg_write_e   (reg_write_e),
        .reg_write_m   (reg_write_m),
        .reg_write_w   (reg_write_w),
        .mem_to_reg_e  (mem_to_reg_e),
        .mem_to_reg_m  (mem_to_reg_m),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .forward_ad    (forward_ad),
        .forward_bd    (forward_bd),
        .forward_ae    (forward_ae),
        .forward_be    (forward_be),
        .dump_regs     (dump_regs),
        .halt          (halt),
        .lw_stall_cnt  (lw_stall_cnt),
        .br_stall_cnt  (br_stall_cnt)
    );

    typedef struct {
        logic       valid, branch, pcsrc;
        logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic       rw_e, rw_m, rw_w, m2r_e, m2r_m;
    } stim_t;

    typedef struct {
        logic             stall_f, stall_d, flush_d, flush_e, fad, fbd, dump, halt;
        logic [1:0]       fae, fbe;
        logic [CNT_W-1:0] lw, br;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: cycle timestamps instead of state counters.
    int cyc, inv_run, det_cyc, m_lw, m_br;

    function automatic void reset_model();
        cyc = 0; inv_run = 0; det_cyc = -1; m_lw = 0; m_br = 0;
    endfunction

    // 0 run, 1 draining, 2 dump cycle, 3 halted
    function automatic int phase();
        if (det_cyc < 0 || cyc <= det_cyc) return 0;
        if (cyc <= det_cyc + DRAIN_CYCLES) return 1;
        if (cyc == det_cyc + DRAIN_CYCLES + 1) return 2;
        return 3;
    endfunction

    function automatic bit hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 0) && (src == dst);
    endfunction

    function automatic logic [1:0] ex_fwd(input logic [4:0] src, input stim_t s);
        if (s.rw_m && hit(src, s.wr_m)) return 2'b10;
        if (s.rw_w && hit(src, s.wr_w)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t quiet_stim();
        stim_t s;
        s = '{default: 0};
        s.valid = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim(input bit valid);
        stim_t s;
        s.valid = valid;
        s.branch = 1'($urandom_range(0, 1));
        s.pcsrc = 1'($urandom_range(0, 1));
        s.rs_d = 5'($urandom_range(0, 7));
        s.rt_d = 5'($urandom_range(0, 7));
        s.rs_e = 5'($urandom_range(0, 7));
        s.rt_e = 5'($urandom_range(0, 7));
        s.wr_e = 5'($urandom_range(0, 7));
        s.wr_m = 5'($urandom_range(0, 7));
        s.wr_w = 5'($urandom_range(0, 7));
        s.rw_e = 1'($urandom_range(0, 1));
        s.rw_m = 1'($urandom_range(0, 1));
        s.rw_w = 1'($urandom_range(0, 1));
        s.m2r_e = 1'($urandom_range(0, 3) == 0);
        s.m2r_m = 1'($urandom_range(0, 3) == 0);
        return s;
    endfunction

    task automatic apply(input stim_t s, input logic rst_val);
        exp_t e;
        bit   lw, br, hold;
        int   ph;
        @(posedge clk);
        #1;
        rst_n = rst_val;
        if (!rst_val) reset_model();
        instr_valid_d = s.valid;  branch_d = s.branch;  pcsrc_d = s.pcsrc;
        rs_d = s.rs_d;  rt_d = s.rt_d;  rs_e = s.rs_e;  rt_e = s.rt_e;
        write_reg_e = s.wr_e;  write_reg_m = s.wr_m;  write_reg_w = s.wr_w;
        reg_write_e = s.rw_e;  reg_write_m = s.rw_m;  reg_write_w = s.rw_w;
        mem_to_reg_e = s.m2r_e;  mem_to_reg_m = s.m2r_m;

        ph = phase();
        lw = s.m2r_e && (hit(s.rs_d, s.rt_e) || hit(s.rt_d, s.rt_e));
        br = s.branch && ((s.rw_e && (hit(s.rs_d, s.wr_e) || hit(s.rt_d, s.wr_e))) ||
                          (s.m2r_m && (hit(s.rs_d, s.wr_m) || hit(s.rt_d, s.wr_m))));
        hold = (ph != 0) || lw || br;
        e.stall_f = hold;
        e.stall_d = hold;
        e.flush_e = hold;
        e.flush_d = s.pcsrc && !hold;
        e.fad  = s.rw_m && hit(s.rs_d, s.wr_m);
        e.fbd  = s.rw_m && hit(s.rt_d, s.wr_m);
        e.fae  = ex_fwd(s.rs_e, s);
        e.fbe  = ex_fwd(s.rt_e, s);
        e.dump = (ph == 2);
        e.halt = (ph == 3);
        e.lw   = CNT_W'(m_lw);
        e.br   = CNT_W'(m_br);
        exp_q.push_back(e);

        if (rst_val) begin
            if (ph == 0) begin
                inv_run = s.valid ? 0 : inv_run + 1;
                if (inv_run == IDLE_LIMIT) det_cyc = cyc;
                if (lw && m_lw < CNT_MAX) m_lw++;
                if (br && !lw && m_br < CNT_MAX) m_br++;
            end
            cyc++;
        end
    endtask

    task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_vec++;
                check("stall_f",    CNT_W'(stall_f),    CNT_W'(mon_e.stall_f));
                check("stall_d",    CNT_W'(stall_d),    CNT_W'(mon_e.stall_d));
                check("flush_d",    CNT_W'(flush_d),    CNT_W'(mon_e.flush_d));
                check("flush_e",    CNT_W'(flush_e),    CNT_W'(mon_e.flush_e));
                check("forward_ad", CNT_W'(forward_ad), CNT_W'(mon_e.fad));
                check("forward_bd", CNT_W'(forward_bd), CNT_W'(mon_e.fbd));
                check("forward_ae", CNT_W'(forward_ae), CNT_W'(mon_e.fae));
                check("forward_be", CNT_W'(forward_be), CNT_W'(mon_e.fbe));
                check("dump_regs",  CNT_W'(dump_regs),  CNT_W'(mon_e.dump));
                check("halt",       CNT_W'(halt),       CNT_W'(mon_e.halt));
                check("lw_cnt",     lw_stall_cnt,       mon_e.lw);
                check("br_cnt",     br_stall_cnt,       mon_e.br);
            end
        end
    end

    task automatic do_reset();
        apply(rand_stim(1'b1), 1'b0);
        apply(rand_stim(1'b1), 1'b0);
    endtask

    task automatic run_idle(input int n, input bit valid);
        stim_t s;
        s = quiet_stim();
        s.valid = valid;
        for (int i = 0; i < n; i++) apply(s, 1'b1);
    endtask

    initial begin
        stim_t s;
        int    burst;
        reset_model();
        do_reset();

        // EX forwarding: MEM over WB, WB alone, register 0.
        s = quiet_stim();
        s.rs_e = 3; s.wr_m = 3; s.rw_m = 1; s.wr_w = 3; s.rw_w = 1;
        apply(s, 1'b1);
        s.rw_m = 0;
        apply(s, 1'b1);
        s = quiet_stim();
        s.rs_e = 0; s.wr_m = 0; s.rw_m = 1; s.rt_e = 6; s.wr_w = 6; s.rw_w = 1;
        apply(s, 1'b1);

        // Load-use stall, with a taken branch suppressed by the stall.
        s = quiet_stim();
        s.m2r_e = 1; s.rt_e = 5; s.rs_d = 5; s.pcsrc = 1;
        apply(s, 1'b1);
        run_idle(1, 1'b1);

        // Branch operand from EX stalls, then forwards from MEM.
        s = quiet_stim();
        s.branch = 1; s.rs_d = 4; s.wr_e = 4; s.rw_e = 1;
        apply(s, 1'b1);
        s.rw_e = 0; s.wr_e = 0; s.wr_m = 4; s.rw_m = 1; s.pcsrc = 1;
        apply(s, 1'b1);

        // Load and branch hazards together: one stall, counted as load.
        s = quiet_stim();
        s.branch = 1; s.m2r_e = 1; s.rt_e = 7; s.rs_d = 7; s.wr_e = 7; s.rw_e = 1;
        apply(s, 1'b1);

        // End of program: drain, dump, halt.
        run_idle(IDLE_LIMIT, 1'b0);
        run_idle(8, 1'b1);

        // Interrupted idle run does not halt early.
        do_reset();
        run_idle(IDLE_LIMIT - 1, 1'b0);
        run_idle(1, 1'b1);
        run_idle(IDLE_LIMIT, 1'b0);
        run_idle(7, 1'b1);

        // Reset in the middle of DRAIN.
        do_reset();
        s = quiet_stim();
        s.m2r_e = 1; s.rt_e = 2; s.rt_d = 2;
        apply(s, 1'b1);
        run_idle(IDLE_LIMIT + 1, 1'b0);
        do_reset();
        run_idle(2, 1'b1);

        // Randomized traffic with occasional end-of-program bursts.
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 499) begin
                do_reset();
            end else begin
                if (burst == 0 && $urandom_range(0, 149) == 0) burst = IDLE_LIMIT + 1;
                apply(rand_stim(burst > 0 ? 1'b0 : 1'($urandom_range(0, 15) != 0)), 1'b1);
                if (burst > 0) burst--;
            end
        end

        // Counter saturation.
        do_reset();
        s = quiet_stim();
        s.m2r_e = 1; s.rt_e = 5; s.rs_d = 5;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) apply(s, 1'b1);
        run_idle(2, 1'b1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
